tcu_drl_k_sched: RTL and testbench
==================================

# tcu_drl_k_sched

K-loop scheduler for the TCU dot-product datapath (exponent-bias/alignment/accumulate pipeline). Accepts one tile command, streams K-step operand chunks into the datapath, and feeds each step's C-term from an internal accumulator buffer holding the previous step's result. Interleaves `NUM_ACC` independent accumulators round-robin to hide datapath latency, tracks in-flight steps with a per-accumulator scoreboard, then drains final results. Sits between the TCU operand-fetch stream and the datapath.

## Interface
- `N`, 2, 32-bit operand words per row/column per step
- `NUM_ACC`, 4, interleaved accumulators (≥1)
- `KW`, 8, width of K-step count
- `AW`, `$clog2(NUM_ACC)` (min 1), accumulator tag width
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `cmd_valid` / `cmd_ready`  in/out  1  command handshake
- `cmd_fmt`  in  3  format ID (`TCU_*_ID`)
- `cmd_ksteps`  in  KW  K steps per accumulator (0 legal)
- `cmd_vld_mask`  in  TCU_MAX_INPUTS  lane mask
- `cmd_c_init`  in  NUM_ACC×32  initial C per accumulator
- `opd_valid` / `opd_ready`  in/out  1  operand stream handshake
- `opd_a_row`, `opd_b_col`  in  N×32  operands, order k-major, acc-minor (k0a0, k0a1, …)
- `dp_valid`  out  1  issue to datapath
- `dp_fmtf`  out  3  registered `cmd_fmt`
- `dp_vld_mask`  out  TCU_MAX_INPUTS  registered mask
- `dp_a_row`, `dp_b_col`  out  N×32  pass-through of operands
- `dp_c_val`  out  32  `acc_buf[cur_acc]`
- `dp_tag`  out  AW  accumulator index
- `dp_rsp_valid`  in  1  datapath result (no backpressure)
- `dp_rsp_tag`  in  AW  result accumulator
- `dp_rsp_data`  in  32  result value
- `res_valid` / `res_ready`  out/in  1  final result handshake
- `res_idx`  out  AW  accumulator index
- `res_data`  out  32  final value
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM IDLE → RUN → WAIT → DRAIN → IDLE.
- IDLE: `cmd_ready`=1. On fire: latch fmt, mask, ksteps; `acc_buf[i]←c_init[i]`; `k←0`, `cur_acc←0`, `pending←0`. Next state RUN, or DRAIN if `cmd_ksteps`=0.
- RUN: issue fires when `opd_valid && !pending[cur_acc]`; `opd_ready` = same condition. On fire: `dp_valid`=1 (combinational, same cycle), `pending[cur_acc]←1`, `cur_acc` increments, wrapping at NUM_ACC−1 to 0 with `k++`. Issue of last (k=ksteps−1, acc=NUM_ACC−1) → WAIT.
- `dp_rsp_valid`: `acc_buf[tag]←data`, `pending[tag]←0`. Response with tag not pending: ignored (sim assertion). No bypass: pending clear is visible to issue the cycle after the response.
- WAIT: until `pending`==0, then DRAIN with `drain_idx←0`.
- DRAIN: `res_valid`=1, `res_idx`=drain_idx, `res_data`=acc_buf[drain_idx]; on `res_ready` increment; after index NUM_ACC−1 fires → IDLE.
- k counter width KW+1 internally; no overflow for ksteps=2^KW−1.
- `dp_*` data outputs are don't-care when `dp_valid`=0; drive 0.

## Timing
- Reset: state IDLE, `cmd_ready`=1 after reset deasserts, `opd_ready`=0, `dp_valid`=0, `res_valid`=0, `busy`=0, `pending`=0, counters 0, `dp_fmtf`/`dp_vld_mask`=0.
- Reset mid-operation: abort immediately, no results emitted; late responses ignored (pending cleared).
- Command accepted cycle t → first possible issue t+1.
- Re-issue of accumulator a: earliest one cycle after its response. With datapath latency LAT and NUM_ACC ≥ LAT+1, one issue per cycle; otherwise (LAT+1−NUM_ACC) bubbles per round.
- Last response cycle r → WAIT exits, first `res_valid` at r+1 (response written before drain reads it).
- Drain: one result per cycle under continuous `res_ready`; `res_valid`/data held stable while stalled.

## Test plan
- ksteps=0, c_init={1.0,2.0,3.0,4.0} → no `dp_valid`; results idx0..3 = 0x3F800000, 0x40000000, 0x40400000, 0x40800000 starting 1 cycle after cmd fire.
- ksteps=3, NUM_ACC=4, model adds 1.0 with LAT=4, c_init all 0 → 12 issues, `dp_c_val` per acc 0.0,1.0,2.0; results all 0x40400000.
- Throughput: LAT=4, NUM_ACC=4, ksteps=8, opd always valid → 32 issues over 39 cycles (one bubble per round); NUM_ACC=5 → 40 issues in 40 consecutive cycles.
- `opd_valid` toggling 1/0 each cycle → issue order k-major preserved, `dp_tag` sequence 0,1,2,3,0…, final sums unchanged.
- `res_ready` low 3 cycles on idx 1 → idx1 data held stable, no skip/duplicate, back to IDLE after idx3.
- Reset asserted in RUN with 2 in flight, then new ksteps=1 command → late old responses ignored; new results equal c_init+1.0.

Source files
------------

// File: rtl/tcu_drl_k_sched.sv
// K-loop scheduler for the TCU dot-product datapath: streams K-step operands
// round-robin over NUM_ACC accumulators, recirculates partial sums, drains results.
module tcu_drl_k_sched #(
  parameter int N              = 2,
  parameter int NUM_ACC        = 4,
  parameter int KW             = 8,
  parameter int TCU_MAX_INPUTS = 8,
  parameter int AW             = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [2:0]                cmd_fmt,
  input  logic [KW-1:0]             cmd_ksteps,
  input  logic [TCU_MAX_INPUTS-1:0] cmd_vld_mask,
  input  logic [NUM_ACC*32-1:0]     cmd_c_init,
  input  logic                      opd_valid,
  output logic                      opd_ready,
  input  logic [N*32-1:0]           opd_a_row,
  input  logic [N*32-1:0]           opd_b_col,
  output logic                      dp_valid,
  output logic [2:0]                dp_fmtf,
  output logic [TCU_MAX_INPUTS-1:0] dp_vld_mask,
  output logic [N*32-1:0]           dp_a_row,
  output logic [N*32-1:0]           dp_b_col,
  output logic [31:0]               dp_c_val,
  output logic [AW-1:0]             dp_tag,
  input  logic                      dp_rsp_valid,
  input  logic [AW-1:0]             dp_rsp_tag,
  input  logic [31:0]               dp_rsp_data,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [AW-1:0]             res_idx,
  output logic [31:0]               res_data,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, RUN, WAIT, DRAIN} state_e;

  localparam logic [AW-1:0] LAST_ACC = AW'(NUM_ACC - 1);

  state_e                      state_q, state_d;
  logic [2:0]                  fmt_q, fmt_d;
  logic [TCU_MAX_INPUTS-1:0]   mask_q, mask_d;
  logic [KW-1:0]               ksteps_q, ksteps_d;
  logic [KW:0]                 k_q, k_d;
  logic [AW-1:0]               cur_acc_q, cur_acc_d;
  logic [AW-1:0]               drain_idx_q, drain_idx_d;
  logic [NUM_ACC-1:0]          pending_q, pending_d;
  logic [31:0]                 acc_buf_q [NUM_ACC];
  logic [31:0]                 acc_buf_d [NUM_ACC];
  logic                        rsp_hit;
  logic                        issue;
  logic                        last_issue;

  always_comb begin
    rsp_hit = 1'b0;
    if (dp_rsp_valid && (int'(dp_rsp_tag) < NUM_ACC)) begin
      rsp_hit = pending_q[dp_rsp_tag];
    end
    issue      = (state_q == RUN) && opd_valid && !pending_q[cur_acc_q];
    last_issue = issue && (cur_acc_q == LAST_ACC) &&
                 ((k_q + (KW+1)'(1)) == {1'b0, ksteps_q});

    state_d     = state_q;
    fmt_d       = fmt_q;
    mask_d      = mask_q;
    ksteps_d    = ksteps_q;
    k_d         = k_q;
    cur_acc_d   = cur_acc_q;
    drain_idx_d = drain_idx_q;
    pending_d   = pending_q;
    acc_buf_d   = acc_buf_q;

    // Responses for accumulators that are not in flight are dropped, which is
    // what makes stragglers from an aborted tile harmless.
    if (rsp_hit) begin
      acc_buf_d[dp_rsp_tag] = dp_rsp_data;
      pending_d[dp_rsp_tag] = 1'b0;
    end
    if (issue) begin
      pending_d[cur_acc_q] = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          fmt_d       = cmd_fmt;
          mask_d      = cmd_vld_mask;
          ksteps_d    = cmd_ksteps;
          k_d         = '0;
          cur_acc_d   = '0;
          drain_idx_d = '0;
          pending_d   = '0;
          for (int i = 0; i < NUM_ACC; i++) begin
            acc_buf_d[i] = cmd_c_init[i*32 +: 32];
          end
          state_d = (cmd_ksteps == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (issue) begin
          if (cur_acc_q == LAST_ACC) begin
            cur_acc_d = '0;
            k_d       = k_q + (KW+1)'(1);
          end else begin
            cur_acc_d = cur_acc_q + AW'(1);
          end
          if (last_issue) begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // Looking at the next pending vector lets the drain start right
        // after the final response lands in acc_buf.
        if (pending_d == '0) begin
          drain_idx_d = '0;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        if (res_ready) begin
          if (drain_idx_q == LAST_ACC) begin
            state_d = IDLE;
          end else begin
            drain_idx_d = drain_idx_q + AW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = (state_q == IDLE);
    opd_ready   = issue;
    dp_valid    = issue;
    dp_fmtf     = issue ? fmt_q : 3'd0;
    dp_vld_mask = issue ? mask_q : '0;
    dp_a_row    = issue ? opd_a_row : '0;
    dp_b_col    = issue ? opd_b_col : '0;
    dp_c_val    = issue ? acc_buf_q[cur_acc_q] : 32'd0;
    dp_tag      = issue ? cur_acc_q : '0;
    res_valid   = (state_q == DRAIN);
    res_idx     = (state_q == DRAIN) ? drain_idx_q : '0;
    res_data    = (state_q == DRAIN) ? acc_buf_q[drain_idx_q] : 32'd0;
    busy        = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      fmt_q       <= '0;
      mask_q      <= '0;
      ksteps_q    <= '0;
      k_q         <= '0;
      cur_acc_q   <= '0;
      drain_idx_q <= '0;
      pending_q   <= '0;
      for (int i = 0; i < NUM_ACC; i++) begin
        acc_buf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      fmt_q       <= fmt_d;
      mask_q      <= mask_d;
      ksteps_q    <= ksteps_d;
      k_q         <= k_d;
      cur_acc_q   <= cur_acc_d;
      drain_idx_q <= drain_idx_d;
      pending_q   <= pending_d;
      acc_buf_q   <= acc_buf_d;
    end
  end

  // While a tile is active every response must target an in-flight accumulator.
  assert property (@(posedge clk) disable iff (reset)
    (dp_rsp_valid && (state_q != IDLE)) |-> rsp_hit);

endmodule

// File: tb/tb_tcu_drl_k_sched.sv
// Scoreboard bench for tcu_drl_k_sched: a LAT-cycle datapath model adds 1.0 per step,
// monitors pop expected issues/results whenever the DUT presents them.
module tb_tcu_drl_k_sched;
  localparam int N = 2, NUM_ACC = 4, KW = 8, MI = 8, AW = 2, LAT = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 cmd_valid = 1'b0, cmd_ready;
  logic [2:0]           cmd_fmt = '0;
  logic [KW-1:0]        cmd_ksteps = '0;
  logic [MI-1:0]        cmd_vld_mask = '0;
  logic [NUM_ACC*32-1:0] cmd_c_init = '0;
  logic                 opd_valid = 1'b0, opd_ready;
  logic [N*32-1:0]      opd_a_row = '0, opd_b_col = '0;
  logic                 dp_valid;
  logic [2:0]           dp_fmtf;
  logic [MI-1:0]        dp_vld_mask;
  logic [N*32-1:0]      dp_a_row, dp_b_col;
  logic [31:0]          dp_c_val;
  logic [AW-1:0]        dp_tag;
  logic                 dp_rsp_valid;
  logic [AW-1:0]        dp_rsp_tag;
  logic [31:0]          dp_rsp_data;
  logic                 res_valid, res_ready = 1'b1;
  logic [AW-1:0]        res_idx;
  logic [31:0]          res_data;
  logic                 busy;

  tcu_drl_k_sched #(.N(N), .NUM_ACC(NUM_ACC), .KW(KW), .TCU_MAX_INPUTS(MI)) u_dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_fmt(cmd_fmt),
    .cmd_ksteps(cmd_ksteps), .cmd_vld_mask(cmd_vld_mask), .cmd_c_init(cmd_c_init),
    .opd_valid(opd_valid), .opd_ready(opd_ready), .opd_a_row(opd_a_row), .opd_b_col(opd_b_col),
    .dp_valid(dp_valid), .dp_fmtf(dp_fmtf), .dp_vld_mask(dp_vld_mask),
    .dp_a_row(dp_a_row), .dp_b_col(dp_b_col), .dp_c_val(dp_c_val), .dp_tag(dp_tag),
    .dp_rsp_valid(dp_rsp_valid), .dp_rsp_tag(dp_rsp_tag), .dp_rsp_data(dp_rsp_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx), .res_data(res_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] tag;
    logic [31:0]   c;
    logic [2:0]    fmt;
    logic [MI-1:0] mask;
    logic [63:0]   a;
    logic [63:0]   b;
  } issue_t;

  typedef struct {
    logic [AW-1:0] idx;
    logic [31:0]   data;
  } res_t;

  issue_t iss_q[$];
  res_t   res_q[$];
  int     iss_cyc[$];
  int     res_cyc[$];
  issue_t issue_exp;
  int     cyc = 0;
  int     checks = 0;
  int     passes = 0;
  int     opd_mode = 0;
  int     fire_cyc = 0;

  function automatic logic [31:0] int2f(int n);
    int e = 0;
    logic [31:0] m;
    if (n == 0) return 32'd0;
    for (int i = 0; i < 31; i++) if (n[i]) e = i;
    m = 32'(n) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  function automatic int f2int(logic [31:0] f);
    int e;
    logic [31:0] m;
    if (f[30:0] == 31'd0) return 0;
    e = int'(f[30:23]) - 127;
    m = {8'd0, 1'b1, f[22:0]};
    return int'(m >> (23 - e));
  endfunction

  function automatic logic [63:0] arow(int s);
    return {32'(s) ^ 32'hA5A5_0000, 32'(s)};
  endfunction

  function automatic logic [63:0] brow(int s);
    return {~32'(s), 32'(s) + 32'h100};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic failNow(input string name);
    checks++;
    $display("[TB] FAIL %s: bound expired or unexpected event", name);
  endtask

  // Datapath model: result = c + 1.0, returned LAT cycles after issue; it is
  // deliberately not reset so aborted work still comes back late.
  logic          pv [LAT] = '{default: 1'b0};
  logic [AW-1:0] pt [LAT] = '{default: '0};
  logic [31:0]   pd [LAT] = '{default: '0};

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    pv[0] <= dp_valid;
    pt[0] <= dp_tag;
    pd[0] <= int2f(f2int(dp_c_val) + 1);
    for (int i = 1; i < LAT; i++) begin
      pv[i] <= pv[i-1];
      pt[i] <= pt[i-1];
      pd[i] <= pd[i-1];
    end
  end

  assign dp_rsp_valid = pv[LAT-1];
  assign dp_rsp_tag   = pt[LAT-1];
  assign dp_rsp_data  = pd[LAT-1];

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (opd_mode)
        1:       opd_valid = 1'b1;
        2:       opd_valid = ~opd_valid;
        default: opd_valid = 1'b0;
      endcase
      opd_a_row = arow(iss_cyc.size());
      opd_b_col = brow(iss_cyc.size());
    end
  end

  always @(negedge clk) begin
    if (!reset && dp_valid) begin
      iss_cyc.push_back(cyc);
      if (iss_q.size() == 0) begin
        failNow("issue_unexpected");
      end else begin
        issue_exp = iss_q.pop_front();
        checkOutput("dp_tag", 64'(dp_tag), 64'(issue_exp.tag));
        checkOutput("dp_c_val", 64'(dp_c_val), 64'(issue_exp.c));
        checkOutput("dp_fmtf", 64'(dp_fmtf), 64'(issue_exp.fmt));
        checkOutput("dp_vld_mask", 64'(dp_vld_mask), 64'(issue_exp.mask));
        checkOutput("dp_a_row", dp_a_row, issue_exp.a);
        checkOutput("dp_b_col", dp_b_col, issue_exp.b);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && res_valid) begin
      if (res_q.size() == 0) begin
        failNow("res_unexpected");
      end else begin
        checkOutput("res_idx", 64'(res_idx), 64'(res_q[0].idx));
        checkOutput("res_data", 64'(res_data), 64'(res_q[0].data));
        if (res_ready) begin
          void'(res_q.pop_front());
          res_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic applyStimulus(input int ks, input int c [4], input logic [2:0] fmt,
                               input logic [MI-1:0] mask, input logic [31:0] rexp [4]);
    int base;
    bit fired = 1'b0;
    issue_t e;
    res_t r;
    base = iss_cyc.size();
    for (int k = 0; k < ks; k++) begin
      for (int a = 0; a < NUM_ACC; a++) begin
        e.tag  = AW'(a);
        e.c    = int2f(c[a] + k);
        e.fmt  = fmt;
        e.mask = mask;
        e.a    = arow(base + k*NUM_ACC + a);
        e.b    = brow(base + k*NUM_ACC + a);
        iss_q.push_back(e);
      end
    end
    for (int a = 0; a < NUM_ACC; a++) begin
      r.idx  = AW'(a);
      r.data = rexp[a];
      res_q.push_back(r);
    end
    @(posedge clk);
    #1;
    cmd_valid  = 1'b1;
    cmd_fmt    = fmt;
    cmd_vld_mask = mask;
    cmd_ksteps = KW'(ks);
    for (int a = 0; a < NUM_ACC; a++) cmd_c_init[a*32 +: 32] = int2f(c[a]);
    for (int t = 0; t < 50 && !fired; t++) begin
      @(negedge clk);
      if (cmd_ready) begin
        fired    = 1'b1;
        fire_cyc = cyc;
      end
    end
    if (!fired) failNow("cmd_accept_timeout");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitDone();
    bit done = 1'b0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      if (!busy && res_q.size() == 0) done = 1'b1;
    end
    if (!done) failNow("done_timeout");
    checkOutput("iss_q_drained", 64'(iss_q.size()), 64'd0);
    checkOutput("res_q_drained", 64'(res_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passes, checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int ib, rb;
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("rst_opd_ready", 64'(opd_ready), 64'd0);
    checkOutput("rst_dp_valid", 64'(dp_valid), 64'd0);
    checkOutput("rst_res_valid", 64'(res_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_dp_fmtf", 64'(dp_fmtf), 64'd0);
    checkOutput("rst_dp_vld_mask", 64'(dp_vld_mask), 64'd0);

    $display("[TB] ksteps=0 passes c_init straight to drain");
    ib = iss_cyc.size();
    rb = res_cyc.size();
    opd_mode = 1;
    applyStimulus(0, '{1, 2, 3, 4}, 3'd1, 8'hFF,
                  '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000});
    waitDone();
    checkOutput("k0_no_issue", 64'(iss_cyc.size() - ib), 64'd0);
    checkOutput("k0_first_res_lat", 64'(res_cyc[rb] - fire_cyc), 64'd1);

    $display("[TB] ksteps=3 accumulate from zero");
    ib = iss_cyc.size();
    applyStimulus(3, '{0, 0, 0, 0}, 3'd2, 8'h0F,
                  '{32'h40400000, 32'h40400000, 32'h40400000, 32'h40400000});
    waitDone();
    checkOutput("k3_issue_count", 64'(iss_cyc.size() - ib), 64'd12);
    checkOutput("k3_first_issue_lat", 64'(iss_cyc[ib] - fire_cyc), 64'd1);

    $display("[TB] ksteps=8 throughput with LAT=4");
    ib = iss_cyc.size();
    applyStimulus(8, '{0, 0, 0, 0}, 3'd5, 8'h33,
                  '{32'h41000000, 32'h41000000, 32'h41000000, 32'h41000000});
    waitDone();
    checkOutput("k8_issue_count", 64'(iss_cyc.size() - ib), 64'd32);
    checkOutput("k8_issue_span", 64'(iss_cyc[ib+31] - iss_cyc[ib]), 64'd38);

    $display("[TB] operand valid toggling");
    opd_mode = 2;
    applyStimulus(2, '{5, 6, 7, 8}, 3'd3, 8'h81,
                  '{32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000});
    waitDone();

    $display("[TB] result backpressure on idx 1");
    opd_mode = 1;
    rb = res_cyc.size();
    applyStimulus(1, '{1, 2, 3, 4}, 3'd4, 8'h3C,
                  '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000});
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      if (res_valid && res_ready && res_idx == 2'd0) seen = 1'b1;
    end
    if (!seen) failNow("stall_idx0_timeout");
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    res_ready = 1'b1;
    waitDone();
    checkOutput("stall_gap", 64'(res_cyc[rb+1] - res_cyc[rb]), 64'd4);
    checkOutput("stall_no_gap_after", 64'(res_cyc[rb+3] - res_cyc[rb+2]), 64'd1);

    $display("[TB] reset in RUN with two steps in flight");
    ib = iss_cyc.size();
    applyStimulus(4, '{0, 0, 0, 0}, 3'd6, 8'hF0,
                  '{32'h40800000, 32'h40800000, 32'h40800000, 32'h40800000});
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      if (iss_cyc.size() >= ib + 2) seen = 1'b1;
    end
    if (!seen) failNow("abort_issue_timeout");
    opd_mode = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    iss_q.delete();
    res_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_cmd_ready", 64'(cmd_ready), 64'd1);
    repeat (8) @(negedge clk);
    checkOutput("abort_no_res", 64'(res_valid), 64'd0);
    opd_mode = 1;
    applyStimulus(1, '{10, 20, 30, 40}, 3'd7, 8'h55,
                  '{32'h41300000, 32'h41A80000, 32'h41F80000, 32'h42240000});
    waitDone();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
